qmac_accum: RTL and testbench

QMAC_ACCUM -- requirements
Module: qmac_accum

---
 rtl/qmac_accum.sv | 161 ++++++++++++++++
 tb/tb_qmac_accum.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmac_accum.sv
// Sign-magnitude fixed-point dot-product engine: a registered multiply stage feeds
// a wide two's-complement accumulator; the result is saturated back to sign-magnitude.
module qmac_accum #(
  parameter int Q   = 15,
  parameter int N   = 32,
  parameter int LEN = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_ovr
);

  localparam int         PW   = 2 * N - 1;
  localparam int         AW   = N + 8;
  localparam logic [7:0] LAST = 8'(LEN - 1);

  typedef enum logic [1:0] {
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [N-1:0]   r_out_result;
  logic           r_out_ovr;
  logic [7:0]     r_cnt;

  logic           r_p_valid;
  logic           r_p_sign;
  logic           r_p_ovr;
  logic [N-2:0]   r_p_mag;
  logic [AW-1:0]  r_acc;
  logic           r_sticky;

  logic           w_accept;
  logic           w_handshake;
  logic [PW-1:0]  w_prod;
  logic [Q-1:0]   w_prod_lo_unused;
  logic [AW-1:0]  w_term;
  logic [AW-1:0]  w_acc_abs;
  logic           w_sat;
  logic [N-1:0]   w_result;

  assign w_accept    = in_valid & r_in_ready;
  assign w_handshake = r_out_valid & out_ready;

  // Full-width magnitude product; bits below Q are truncated away.
  assign w_prod           = PW'(in_a[N-2:0]) * PW'(in_b[N-2:0]);
  assign w_prod_lo_unused = w_prod[Q-1:0];

  // Negative zero negates to zero, so it contributes nothing to the sum.
  assign w_term = r_p_sign ? (AW'(0) - AW'(r_p_mag)) : AW'(r_p_mag);

  assign w_acc_abs = r_acc[AW-1] ? (AW'(0) - r_acc) : r_acc;
  assign w_sat     = |w_acc_abs[AW-1:N-1];
  assign w_result  = w_sat ? {r_acc[AW-1], {(N-1){1'b1}}}
                           : {r_acc[AW-1], w_acc_abs[N-2:0]};

  // Product register, accumulator and sticky overflow flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always_ff blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_sign  <= 1'b0;
      r_p_ovr   <= 1'b0;
      r_p_mag   <= '0;
      r_acc     <= '0;
      r_sticky  <= 1'b0;
    end else if (clr) begin
      r_p_valid <= 1'b0;
      r_p_sign  <= 1'b0;
      r_p_ovr   <= 1'b0;
      r_p_mag   <= '0;
      r_acc     <= '0;
      r_sticky  <= 1'b0;
    end else begin
      r_p_valid <= w_accept;
      if (w_accept) begin
        r_p_mag  <= w_prod[N-2+Q:Q];
        r_p_sign <= in_a[N-1] ^ in_b[N-1];
        r_p_ovr  <= |w_prod[PW-1:N-1+Q];
      end
      if (w_handshake) begin
        r_acc    <= '0;
        r_sticky <= 1'b0;
      end else if (r_p_valid) begin
        r_acc    <= r_acc + w_term;
        r_sticky <= r_sticky | r_p_ovr;
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ACCUM;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovr    <= 1'b0;
      r_cnt        <= '0;
    end else if (clr) begin
      r_state     <= S_ACCUM;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            if (r_cnt == LAST) begin
              r_cnt      <= '0;
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          // Wait until the final product has landed in the accumulator.
          if (!r_p_valid) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_out_result <= w_result;
            r_out_ovr    <= w_sat | r_sticky;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
          end
        end
        default: begin
          r_state    <= S_ACCUM;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_ovr    = r_out_ovr;

endmodule

// File: tb/tb_qmac_accum.sv
// Directed and random checks of qmac_accum against a queue of expected results,
// covering latency, signs, saturation, backpressure, abort and reset.
module tb_qmac_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_ovr;

  typedef struct {
    logic [31:0] res;
    logic        ovr;
  } exp_t;

  exp_t    sb_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  longint  m_acc;
  logic    m_ovr;

  localparam logic [31:0] ONE  = 32'h0000_8000;
  localparam logic [31:0] MONE = 32'h8000_8000;

  qmac_accum #(.Q(15), .N(32), .LEN(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovr    (out_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] res, input logic ovr);
    exp_t e;
    e.res = res;
    e.ovr = ovr;
    sb_q.push_back(e);
  endtask

  // Offer one pair until it is accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int   n = 0;
    logic took;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    do begin
      took = in_ready;
      tick();
      n++;
    end while (!took && n < 50);
    in_valid = 1'b0;
    if (!took) check("accept_timeout", 0, 1);
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_ovr = 1'b0;
  endtask

  // Reference arithmetic for Q=15, N=32.
  task automatic send_m(input logic [31:0] a, input logic [31:0] b);
    longint unsigned full;
    longint          mag;
    full = longint'(a[30:0]) * longint'(b[30:0]);
    mag  = longint'((full >> 15) & 64'h7FFF_FFFF);
    if ((full >> 46) != 0) m_ovr = 1'b1;
    m_acc = (a[31] ^ b[31]) ? m_acc - mag : m_acc + mag;
    send(a, b);
  endtask

  task automatic model_push();
    longint      abs_v;
    logic [31:0] res;
    logic        ovr;
    abs_v = (m_acc < 0) ? -m_acc : m_acc;
    ovr   = m_ovr;
    if (abs_v > 64'sh7FFF_FFFF) begin
      res = {(m_acc < 0), 31'h7FFF_FFFF};
      ovr = 1'b1;
    end else begin
      res = {(m_acc < 0), abs_v[30:0]};
    end
    push(res, ovr);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic get_result(input string tag);
    exp_t e;
    out_ready = 1'b0;
    wait_valid(tag);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_result"}, out_result, e.res);
    check({tag, "_ovr"}, out_ovr, e.ovr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ack_valid"}, out_valid, 0);
    check({tag, "_ack_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] held_res;
    logic        held_ovr;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_ovr", out_ovr, 0);
    rst_n = 1'b1;
    tick();

    // Nine 1.0*1.0 with latency checks on the final accept
    push(32'h0004_8000, 1'b0);
    for (int i = 0; i < 9; i++) send(ONE, ONE);
    check("lat_t0_valid", out_valid, 0);
    check("lat_t0_ready", in_ready, 0);
    tick();
    check("lat_t1_valid", out_valid, 0);
    tick();
    check("lat_t2_valid", out_valid, 1);
    get_result("nine_ones");

    // Mixed signs: 5 - 4 = 1.0
    push(32'h0000_8000, 1'b0);
    for (int i = 0; i < 5; i++) send(ONE, ONE);
    for (int i = 0; i < 4; i++) send(MONE, ONE);
    get_result("mixed_sign");

    // Cancellation plus negative zero gives positive zero
    push(32'h0000_0000, 1'b0);
    for (int i = 0; i < 4; i++) send(ONE, ONE);
    for (int i = 0; i < 4; i++) send(MONE, ONE);
    send(32'h8000_0000, ONE);
    get_result("neg_zero");

    // Product overflow is sticky even though the sum is zero
    push(32'h0000_0000, 1'b1);
    send(32'h4000_0000, 32'h0001_0000);
    for (int i = 0; i < 8; i++) send(32'h0, 32'h0);
    get_result("prod_ovr");

    // Positive and negative accumulator saturation
    push(32'h7FFF_FFFF, 1'b1);
    for (int i = 0; i < 9; i++) send(32'h2000_0000, ONE);
    get_result("sat_pos");
    push(32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 9; i++) send(32'hA000_0000, ONE);
    get_result("sat_neg");

    // Backpressure: result held, extra pairs ignored, counter untouched
    push(32'h0004_8000, 1'b0);
    for (int i = 0; i < 9; i++) send(32'h0001_0000, 32'h0000_4000);
    wait_valid("bp");
    held_res = out_result;
    held_ovr = out_ovr;
    in_a = 32'h0007_0000; in_b = 32'h0007_0000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_result", out_result, held_res);
      check("bp_hold_ovr", out_ovr, held_ovr);
    end
    in_valid = 1'b0;
    get_result("bp");
    push(32'h0012_0000, 1'b0);
    for (int i = 0; i < 9; i++) send(32'h0001_0000, 32'h0001_0000);
    get_result("bp_after");

    // Abort after four accepts; the pair offered with clr is dropped
    for (int i = 0; i < 4; i++) send(32'h0001_0000, 32'h0001_0000);
    in_a = 32'h0003_0000; in_b = 32'h0003_0000; in_valid = 1'b1; clr = 1'b1;
    tick();
    in_valid = 1'b0; clr = 1'b0;
    check("clr_ready", in_ready, 1);
    check("clr_valid", out_valid, 0);
    push(32'h0004_8000, 1'b0);
    for (int i = 0; i < 9; i++) send(ONE, ONE);
    get_result("after_clr");

    // clr wins over the DONE handshake
    for (int i = 0; i < 9; i++) send(ONE, ONE);
    wait_valid("clr_done");
    clr = 1'b1; out_ready = 1'b1;
    tick();
    clr = 1'b0; out_ready = 1'b0;
    check("clr_done_valid", out_valid, 0);
    check("clr_done_ready", in_ready, 1);

    // Asynchronous reset mid-accumulation
    for (int i = 0; i < 6; i++) send(ONE, ONE);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_ready", in_ready, 1);
    check("arst_mid_valid", out_valid, 0);
    check("arst_mid_result", out_result, 0);
    check("arst_mid_ovr", out_ovr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset while a result is held
    for (int i = 0; i < 9; i++) send(32'h2000_0000, ONE);
    wait_valid("arst_done");
    #2 rst_n = 1'b0;
    #1;
    check("arst_done_valid", out_valid, 0);
    check("arst_done_result", out_result, 0);
    check("arst_done_ovr", out_ovr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Random runs against the reference model, small then full range
    for (int r = 0; r < 4; r++) begin
      model_clear();
      for (int i = 0; i < 9; i++) begin
        logic [31:0] a;
        logic [31:0] b;
        if (r < 2) begin
          a = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h00FF_FFFF))};
          b = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0000_FFFF))};
        end else begin
          a = $urandom;
          b = $urandom;
        end
        send_m(a, b);
      end
      model_push();
      get_result("random");
    end

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
